// File: rtl/rpn_pkg.sv
// Shared types for the RPN stack sequencer: opcodes, FSM states, default widths.
package rpn_pkg;

  localparam int RPN_DW    = 23;
  localparam int RPN_DEPTH = 128;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_END = 2'b11
  } opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_POP_A  = 3'd1,
    ST_PUSH_R = 3'd2,
    ST_FIN    = 3'd3,
    ST_ERR    = 3'd4
  } state_t;

endpackage

// File: rtl/rpn_stack_ctrl_if.sv
// Token stream into the RPN sequencer (valid/ready handshake).
interface rpn_stack_ctrl_if #(
  parameter int DW = rpn_pkg::RPN_DW
) ();

  logic          tok_valid;
  logic          tok_ready;
  logic          tok_is_op;
  logic [DW-1:0] tok_data;

  modport master (output tok_valid, output tok_is_op, output tok_data, input tok_ready);
  modport slave  (input tok_valid, input tok_is_op, input tok_data, output tok_ready);

endinterface

// File: rtl/rpn_alu.sv
// Combinational RPN arithmetic, two's-complement wrap to DW bits.
// Multiply is only present when RPN_MUL_EN is defined.
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int DW = RPN_DW
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  opcode_t       op,
  output logic [DW-1:0] y
);

  logic signed [DW-1:0] sa;
  logic signed [DW-1:0] sb;

  function automatic logic signed [DW-1:0] wrap_dw(input logic signed [2*DW-1:0] v);
    return v[DW-1:0];
  endfunction

  assign sa = a;
  assign sb = b;

  always_comb begin
    y = '0;
    case (op)
      OP_ADD: y = wrap_dw((2*DW)'(sa) + (2*DW)'(sb));
      OP_SUB: y = wrap_dw((2*DW)'(sa) - (2*DW)'(sb));
`ifdef RPN_MUL_EN
      OP_MUL: y = wrap_dw((2*DW)'(sa) * (2*DW)'(sb));
`endif
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/rpn_stack_ctrl.sv
// RPN expression sequencer driving an external LIFO's push/pop pins.
// RPN_MUL_EN enables opcode 10 (multiply); otherwise it is an illegal token.
module rpn_stack_ctrl
  import rpn_pkg::*;
#(
  parameter int DW    = RPN_DW,
  parameter int DEPTH = RPN_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  rpn_stack_ctrl_if.slave          tok_if,
  output logic [DW-1:0]            stk_in,
  output logic                     stk_push,
  output logic                     stk_pop,
  output logic                     stk_top,
  input  logic [DW-1:0]            stk_dout,
  output logic                     res_valid,
  output logic [DW-1:0]            res_data,
  output logic                     err,
  output logic [$clog2(DEPTH):0]   depth
);

  localparam int DEPTH_W = $clog2(DEPTH) + 1;
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(DEPTH);
  localparam logic [DEPTH_W-1:0] ONE       = DEPTH_W'(1);
  localparam logic [DEPTH_W-1:0] TWO       = DEPTH_W'(2);
`ifdef RPN_MUL_EN
  localparam bit MUL_OK = 1'b1;
`else
  localparam bit MUL_OK = 1'b0;
`endif

  state_t               state, state_nx;
  logic [DEPTH_W-1:0]   depth_nx;
  opcode_t              opc;
  opcode_t              op_p0;
  logic [DW-1:0]        b_p1;
  logic [DW-1:0]        alu_y;
  logic                 op_ld;
  logic                 b_ld;

  rpn_alu #(.DW(DW)) u_alu (
    .a  (stk_dout),
    .b  (b_p1),
    .op (op_p0),
    .y  (alu_y)
  );

  assign stk_top = 1'b0;
  assign err     = (state == ST_ERR);

  // Strobes are gated by rst so the stack sees nothing while reset is held.
  always_comb begin
    state_nx         = state;
    depth_nx         = depth;
    tok_if.tok_ready = 1'b0;
    stk_push         = 1'b0;
    stk_pop          = 1'b0;
    stk_in           = '0;
    op_ld            = 1'b0;
    b_ld             = 1'b0;
    opc              = opcode_t'(tok_if.tok_data[1:0]);
    case (state)
      ST_IDLE: begin
        tok_if.tok_ready = !rst;
        if (tok_if.tok_valid && !rst) begin
          if (!tok_if.tok_is_op) begin
            if (depth == DEPTH_MAX) begin
              state_nx = ST_ERR;
            end else begin
              stk_push = 1'b1;
              stk_in   = tok_if.tok_data;
              depth_nx = depth + ONE;
            end
          end else if (opc == OP_END) begin
            if (depth != ONE) begin
              state_nx = ST_ERR;
            end else begin
              stk_pop  = 1'b1;
              depth_nx = depth - ONE;
              state_nx = ST_FIN;
            end
          end else if ((opc == OP_MUL && !MUL_OK) || depth < TWO) begin
            state_nx = ST_ERR;
          end else begin
            stk_pop  = 1'b1;
            op_ld    = 1'b1;
            depth_nx = depth - ONE;
            state_nx = ST_POP_A;
          end
        end
      end
      ST_POP_A: begin
        b_ld     = 1'b1;
        stk_pop  = !rst;
        depth_nx = depth - ONE;
        state_nx = ST_PUSH_R;
      end
      ST_PUSH_R: begin
        stk_in   = alu_y;
        stk_push = !rst;
        depth_nx = depth + ONE;
        state_nx = ST_IDLE;
      end
      ST_FIN: begin
        state_nx = ST_IDLE;
      end
      ST_ERR: begin
        tok_if.tok_ready = !rst;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Control and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      depth     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      state     <= state_nx;
      depth     <= depth_nx;
      res_valid <= (state == ST_FIN);
      if (state == ST_FIN) begin
        res_data <= stk_dout;
      end
    end
  end

  // Operand/opcode capture: p0 at operator accept, p1 when b returns from the stack.
  always_ff @(posedge clk) begin
    if (op_ld) begin
      op_p0 <= opc;
    end
    if (b_ld) begin
      b_p1 <= stk_dout;
    end
  end

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Bench for rpn_stack_ctrl: behavioural LIFO, token-level RPN reference model, directed + random streams.
module tb_rpn_stack_ctrl;
  import rpn_pkg::*;

  localparam int DW    = 23;
  localparam int DEPTH = 128;
`ifdef RPN_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rpn_stack_ctrl_if #(.DW(DW)) tif ();

  logic [DW-1:0] stk_in, stk_dout, res_data;
  logic          stk_push, stk_pop, stk_top, res_valid, err;
  logic [7:0]    depth;

  rpn_stack_ctrl #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .tok_if    (tif),
    .stk_in    (stk_in),
    .stk_push  (stk_push),
    .stk_pop   (stk_pop),
    .stk_top   (stk_top),
    .stk_dout  (stk_dout),
    .res_valid (res_valid),
    .res_data  (res_data),
    .err       (err),
    .depth     (depth)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural LIFO: registered read data the cycle after a pop.
  logic [DW-1:0] smem [0:DEPTH-1];
  int            sp;
  int            strobe_viol = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= 0;
    end else if (stk_push && stk_pop) begin
      strobe_viol <= strobe_viol + 1;
    end else if (stk_push) begin
      if (sp < DEPTH) begin
        smem[sp] <= stk_in;
        sp       <= sp + 1;
      end else begin
        strobe_viol <= strobe_viol + 1;
      end
    end else if (stk_pop) begin
      if (sp > 0) begin
        stk_dout <= smem[sp-1];
        sp       <= sp - 1;
      end else begin
        strobe_viol <= strobe_viol + 1;
      end
    end
  end

  int res_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (res_valid) res_cnt++;
  end

  // Token-level reference model.
  logic [DW-1:0] mq[$];
  bit            err_m = 1'b0;
  int            res_cnt_m = 0;
  logic [DW-1:0] res_m = '0;

  function automatic void model_tok(input bit is_op, input logic [DW-1:0] d);
    logic [DW-1:0] a, b, r;
    if (err_m) return;
    if (!is_op) begin
      if (mq.size() == DEPTH) err_m = 1'b1;
      else mq.push_back(d);
      return;
    end
    if (d[1:0] == 2'b11) begin
      if (mq.size() != 1) err_m = 1'b1;
      else begin
        res_m = mq.pop_back();
        res_cnt_m++;
      end
    end else if (mq.size() < 2 || (d[1:0] == 2'b10 && !MUL_EN)) begin
      err_m = 1'b1;
    end else begin
      b = mq.pop_back();
      a = mq.pop_back();
      case (d[1:0])
        2'b00:   r = a + b;
        2'b01:   r = a - b;
        default: r = a * b;
      endcase
      mq.push_back(r);
    end
  endfunction

  task automatic check_state();
    int n;
    n = 0;
    @(negedge clk);
    while (!tif.tok_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("idle_timeout", 32'd0, 32'd1);
    chk("depth", 32'(depth), 32'(mq.size()));
    chk("err", 32'(err), 32'(err_m));
    chk("stack_sp", 32'(sp), 32'(mq.size()));
    if (mq.size() > 0 && sp > 0 && sp <= DEPTH) chk("stack_top", 32'(smem[sp-1]), 32'(mq[$]));
    chk("res_cnt", 32'(res_cnt), 32'(res_cnt_m));
    chk("res_data", 32'(res_data), 32'(res_m));
    chk("strobe_viol", 32'(strobe_viol), 32'd0);
  endtask

  task automatic send(input bit is_op, input logic [DW-1:0] d, input bit do_chk);
    int n;
    @(negedge clk);
    tif.tok_valid = 1'b1;
    tif.tok_is_op = is_op;
    tif.tok_data  = d;
    #1;
    n = 0;
    while (!tif.tok_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) begin
      chk("accept_timeout", 32'd0, 32'd1);
      tif.tok_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_tok(is_op, d);
    #1;
    tif.tok_valid = 1'b0;
    if (do_chk) check_state();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    tif.tok_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mq.delete();
    err_m = 1'b0;
    res_m = '0;
  endtask

  logic       lp [0:9];
  logic       lo [0:9];
  logic       lr [0:9];
  logic [DW-1:0] li [0:9];

  initial begin
    #900000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tif.tok_valid = 1'b0;
    tif.tok_is_op = 1'b0;
    tif.tok_data  = '0;
    repeat (2) @(negedge clk);
    // Reset values, with an operand offered while rst is held.
    tif.tok_valid = 1'b1;
    tif.tok_data  = 23'd5;
    #1;
    chk("rst_depth", 32'(depth), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_push", 32'(stk_push), 32'd0);
    chk("rst_pop", 32'(stk_pop), 32'd0);
    chk("rst_stk_in", 32'(stk_in), 32'd0);
    chk("rst_stk_top", 32'(stk_top), 32'd0);
    tif.tok_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // 3 4 ADD END with back-to-back offers; cycle-accurate strobe trace.
    @(posedge clk);
    #1;
    fork
      begin
        for (int k = 0; k < 10; k++) begin
          @(posedge clk);
          lp[k] = stk_push; lo[k] = stk_pop; lr[k] = res_valid; li[k] = stk_in;
        end
      end
      begin
        send(1'b0, 23'd3, 1'b0);
        send(1'b0, 23'd4, 1'b0);
        send(1'b1, 23'd0, 1'b0);
        send(1'b1, 23'd3, 1'b0);
      end
    join
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("trace_push_c%0d", k), 32'(lp[k]), 32'(k == 0 || k == 1 || k == 4));
      chk($sformatf("trace_pop_c%0d", k), 32'(lo[k]), 32'(k == 2 || k == 3 || k == 5));
      chk($sformatf("trace_resv_c%0d", k), 32'(lr[k]), 32'(k == 7));
    end
    chk("trace_in_c0", 32'(li[0]), 32'd3);
    chk("trace_in_c1", 32'(li[1]), 32'd4);
    chk("trace_in_c4", 32'(li[4]), 32'd7);
    check_state();
    chk("add_res", 32'(res_data), 32'd7);

    send(1'b0, 23'd10, 1'b1); send(1'b0, 23'd4, 1'b1); send(1'b1, 23'd1, 1'b1); send(1'b1, 23'd3, 1'b1);
    chk("sub_res", 32'(res_data), 32'd6);
    send(1'b0, 23'd4, 1'b1); send(1'b0, 23'd10, 1'b1); send(1'b1, 23'd1, 1'b1); send(1'b1, 23'd3, 1'b1);
    chk("sub_neg_res", 32'(res_data), 32'h7FFFFA);
    send(1'b0, 23'h7FFFFF, 1'b1); send(1'b0, 23'd1, 1'b1); send(1'b1, 23'd0, 1'b1); send(1'b1, 23'd3, 1'b1);
    chk("wrap_res", 32'(res_data), 32'd0);

    send(1'b0, 23'd5, 1'b1); send(1'b0, 23'd6, 1'b1); send(1'b1, 23'd2, 1'b1); send(1'b1, 23'd3, 1'b1);
    if (MUL_EN) chk("mul_res", 32'(res_data), 32'd30);
    else        chk("mul_illegal_err", 32'(err), 32'd1);
    do_reset();

    // Underflow, then END discarded in ERR.
    send(1'b0, 23'd7, 1'b1); send(1'b1, 23'd0, 1'b1);
    chk("underflow_err", 32'(err), 32'd1);
    send(1'b1, 23'd3, 1'b1);
    do_reset();

    // Fill to capacity, then overflow.
    for (int i = 0; i < DEPTH; i++) send(1'b0, DW'($urandom()), 1'b1);
    chk("full_depth", 32'(depth), 32'd128);
    send(1'b0, 23'd9, 1'b1);
    chk("overflow_err", 32'(err), 32'd1);
    chk("overflow_sp", 32'(sp), 32'd128);
    do_reset();

    // rst asserted while in POP_A.
    send(1'b0, 23'd1, 1'b1); send(1'b0, 23'd2, 1'b1);
    @(negedge clk);
    tif.tok_valid = 1'b1; tif.tok_is_op = 1'b1; tif.tok_data = 23'd0;
    @(posedge clk);
    #1;
    tif.tok_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_depth", 32'(depth), 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    chk("midrst_pop", 32'(stk_pop), 32'd0);
    chk("midrst_push", 32'(stk_push), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mq.delete(); err_m = 1'b0; res_m = '0;
    #1;
    chk("midrst_idle_ready", 32'(tif.tok_ready), 32'd1);
    send(1'b0, 23'd2, 1'b1); send(1'b0, 23'd2, 1'b1); send(1'b1, 23'd0, 1'b1); send(1'b1, 23'd3, 1'b1);
    chk("post_rst_res", 32'(res_data), 32'd4);

    // Random expression streams, occasionally illegal.
    for (int r = 0; r < 40; r++) begin
      int            ntok, s, pick;
      bit            is_op;
      logic [DW-1:0] d;
      ntok = $urandom_range(4, 14);
      for (int t = 0; t < ntok; t++) begin
        s    = mq.size();
        pick = $urandom_range(0, 15);
        d    = ($urandom_range(0, 1) == 0) ? DW'($urandom_range(0, 15)) : DW'($urandom());
        if (pick == 0) begin
          is_op = 1'b1; d[1:0] = 2'b11;
        end else if (pick == 1) begin
          is_op = 1'b1; d[1:0] = 2'($urandom_range(0, 2));
        end else if (pick >= 8 && s >= 2) begin
          is_op = 1'b1; d[1:0] = 2'($urandom_range(0, 2));
        end else begin
          is_op = 1'b0;
        end
        send(is_op, d, ($urandom_range(0, 2) != 0));
      end
      if (!err_m) begin
        while (mq.size() > 1) send(1'b1, 23'd0, 1'b1);
        if (mq.size() == 1) send(1'b1, 23'd3, 1'b1);
      end
      check_state();
      do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
